// File: rtl/dcache_controller.sv
// Direct-mapped, write-back, write-allocate data cache for the MEM stage.
// Hits return combinationally. A miss stalls the pipeline while the FSM
// writes back a dirty victim, if there is one, and then refills the line
// over a req/ack line-granular memory port.
module dcache_controller #(
   parameter int NUM_LINES = 16
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         cpu_req_i,
   input  logic         cpu_we_i,
   input  logic [31:0]  cpu_addr_i,
   input  logic [31:0]  cpu_data_i,
   output logic [31:0]  cpu_data_o,
   output logic         cpu_stall_o,
   output logic         mem_req_o,
   output logic         mem_we_o,
   output logic [31:0]  mem_addr_o,
   output logic [255:0] mem_data_o,
   input  logic [255:0] mem_data_i,
   input  logic         mem_ack_i
);

   localparam int IDX_W = $clog2(NUM_LINES);
   localparam int TAG_W = 27 - IDX_W;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_WB    = 2'd1;
   localparam logic [1:0] S_ALLOC = 2'd2;

   logic [NUM_LINES-1:0] valid_q, dirty_q;
   logic [TAG_W-1:0]     tag_q  [NUM_LINES];
   logic [255:0]         line_q [NUM_LINES];
   logic [1:0]           state_q;
   // Line address of the missing request, latched so the refill completes
   // even if the CPU drops its request mid-miss.
   logic [26:0]          miss_line_q;

   logic [IDX_W-1:0] idx, fill_idx;
   logic [TAG_W-1:0] tag, fill_tag;
   logic [2:0]       wsel;
   logic             hit, fill_done, store_hit;
   logic             unused_bits;

   assign idx         = cpu_addr_i[5 +: IDX_W];
   assign tag         = cpu_addr_i[31 -: TAG_W];
   assign wsel        = cpu_addr_i[4:2];
   assign fill_idx    = miss_line_q[IDX_W-1:0];
   assign fill_tag    = miss_line_q[26 -: TAG_W];
   assign unused_bits = ^cpu_addr_i[1:0];

   assign hit         = valid_q[idx] && (tag_q[idx] == tag);
   assign cpu_data_o  = hit ? line_q[idx][{wsel, 5'b0} +: 32] : 32'h0;
   assign cpu_stall_o = (state_q != S_IDLE) || (cpu_req_i && !hit);
   assign fill_done   = (state_q == S_ALLOC) && mem_ack_i;
   assign store_hit   = (state_q == S_IDLE) && cpu_req_i && cpu_we_i && hit;

   // Miss FSM and registered memory-port outputs; the port is held steady
   // until the ack closes the current transaction.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q     <= S_IDLE;
         mem_req_o   <= 1'b0;
         mem_we_o    <= 1'b0;
         mem_addr_o  <= 32'h0;
         mem_data_o  <= 256'h0;
         miss_line_q <= 27'h0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (cpu_req_i && !hit) begin
                  miss_line_q <= cpu_addr_i[31:5];
                  mem_req_o   <= 1'b1;
                  if (valid_q[idx] && dirty_q[idx]) begin
                     state_q    <= S_WB;
                     mem_we_o   <= 1'b1;
                     mem_addr_o <= {tag_q[idx], idx, 5'b0};
                     mem_data_o <= line_q[idx];
                  end else begin
                     state_q    <= S_ALLOC;
                     mem_we_o   <= 1'b0;
                     mem_addr_o <= {cpu_addr_i[31:5], 5'b0};
                  end
               end
            end
            S_WB: begin
               // Chain straight into the refill without dropping the request.
               if (mem_ack_i) begin
                  state_q    <= S_ALLOC;
                  mem_we_o   <= 1'b0;
                  mem_addr_o <= {miss_line_q, 5'b0};
               end
            end
            S_ALLOC: begin
               if (mem_ack_i) begin
                  state_q   <= S_IDLE;
                  mem_req_o <= 1'b0;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   // Line state bits: cleared by reset, set by refill and store hits.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         valid_q <= '0;
         dirty_q <= '0;
      end else if (fill_done) begin
         valid_q[fill_idx] <= 1'b1;
         dirty_q[fill_idx] <= 1'b0;
      end else if (store_hit) begin
         dirty_q[idx] <= 1'b1;
      end
   end

   // Tag and data arrays carry no reset; valid bits guard them.
   always_ff @(posedge clk_i) begin
      if (fill_done) begin
         line_q[fill_idx] <= mem_data_i;
         tag_q[fill_idx]  <= fill_tag;
      end else if (store_hit) begin
         line_q[idx][{wsel, 5'b0} +: 32] <= cpu_data_i;
      end
   end

endmodule

// File: doc/dcache_controller.md
Name: dcache_controller

Overview:
Direct-mapped, write-back, write-allocate data cache between the pipeline's MEM stage and a multi-cycle line-granular data memory. It replaces the single-cycle data memory path. Hits complete combinationally in the MEM cycle. On a miss, cpu_stall_o is raised so the pipeline freezes, and an FSM performs an optional dirty-line writeback and then a 256-bit line refill over a req/ack memory handshake.

Parameters:
NUM_LINES, 16, number of cache lines; power of two, >= 2. IDX_W = log2(NUM_LINES).

Ports:
clk_i  in  1  clock
rst_i  in  1  reset, asynchronous, active-high
cpu_req_i  in  1  MEM-stage load/store request
cpu_we_i  in  1  1 = store, 0 = load
cpu_addr_i  in  32  byte address, word aligned
cpu_data_i  in  32  store data
cpu_data_o  out  32  load data
cpu_stall_o  out  1  freeze pipeline
mem_req_o  out  1  memory transaction request
mem_we_o  out  1  1 = line write, 0 = line read
mem_addr_o  out  32  line address, bits [4:0] = 0
mem_data_o  out  256  writeback line
mem_data_i  in  256  refill line, valid when mem_ack_i = 1
mem_ack_i  in  1  transaction complete (one-cycle pulse)

Behaviour:
- Address split: offset [4:0], word select [4:2], index [5+IDX_W-1:5], tag [31:5+IDX_W] (23 bits at default).
- Storage is internal registers: valid, dirty, tag and a 256-bit data line per entry.
- Reset clears all valid and dirty bits and puts the FSM in IDLE. The data and tag arrays are not reset.
- Reset values: mem_req_o=0, mem_we_o=0, mem_addr_o=0, mem_data_o=0.
- After reset, cpu_stall_o = cpu_req_i, because every line is invalid.
- mem_* outputs are registered. They are held stable while mem_req_o=1 until the cycle mem_ack_i=1 is sampled.
- hit = valid[idx] & (tag[idx] == addr tag).
- cpu_data_o = selected word of line[idx] when hit, else 0.
- cpu_stall_o = (state != IDLE) | (cpu_req_i & ~hit).
- The CPU holds cpu_req_i, cpu_we_i, cpu_addr_i and cpu_data_i stable while stalled.
- Store hit in IDLE: at the clock edge, the selected word is written and dirty[idx] is set. There is no stall and no memory traffic.
- FSM states: IDLE, WRITEBACK, ALLOCATE.
- IDLE, request misses and the victim is valid and dirty:
  - next state WRITEBACK;
  - load mem_addr_o = {victim tag, idx, 5'b0}, mem_we_o=1, mem_data_o=victim line, mem_req_o=1.
- IDLE, request misses and the victim is clean or invalid:
  - next state ALLOCATE;
  - load mem_addr_o = {req tag, idx, 5'b0}, mem_we_o=0, mem_req_o=1.
- WRITEBACK, on mem_ack_i:
  - next state ALLOCATE in the following cycle;
  - mem_req_o stays 1; address switches to the request line and mem_we_o=0.
  - Back-to-back transactions are legal because each ack closes exactly one transaction.
- ALLOCATE, on mem_ack_i:
  - write mem_data_i into line[idx], tag[idx]=req tag, valid=1, dirty=0;
  - mem_req_o=0; next state IDLE.
  - The held request then hits. A store merges its word at that edge and sets dirty.
- Latency, clean miss with ack arriving k cycles after mem_req_o rises: stall lasts k+2 cycles, counting from the miss-detect cycle through the ack cycle plus the IDLE hit cycle, which is unstalled. A dirty miss adds the writeback ack time.
- mem_ack_i while IDLE is ignored.
- cpu_req_i dropping mid-miss: the in-flight writeback and refill still complete, then the FSM returns to IDLE.
- Reset asserted mid-transaction:
  - mem_req_o falls immediately (asynchronously);
  - the FSM goes to IDLE and all lines are invalidated;
  - a late mem_ack_i after reset is ignored.

Test Plan:
- Reset, then load 0x40 with the memory line at 0x40 holding words 0x1000+i → stall; one mem read at mem_addr_o=0x40; cpu_data_o=0x1000 on the first unstalled cycle; a load of 0x44 next hits with no stall and returns 0x1001.
- Store 0xDEADBEEF to 0x44 after that fill → no stall and no mem_req_o; a load of 0x44 returns 0xDEADBEEF.
- Load 0x240 (same index 2, different tag), memory acks after 10 cycles → writeback at 0x40 with mem_data_o word1=0xDEADBEEF and mem_we_o=1; then a read at 0x240; stall released and correct data returned.
- Load 0x440 while the index-2 line is clean → no writeback, only a read at 0x440; store miss to 0x460 → line allocated, word merged, line dirty (proved by a later conflict writeback containing the word).
- Assert rst_i during ALLOCATE → mem_req_o=0 within the same cycle, FSM in IDLE; a late ack is ignored; a following load of 0x44 misses again.
- Spurious mem_ack_i pulses in IDLE and ack on the first request cycle (k=1) → state unchanged by the spurious pulses, and the k=1 miss releases the stall after exactly 3 cycles.
